// File: rtl/sha3_pad_packer.sv
// sha3_pad_packer: packs 64-bit message lanes into SHA3 rate blocks,
// applies pad10*1 with a domain byte and hands blocks out over valid/ready.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     message lane handshake
//   in_data/in_last       lane data (byte 0 in [7:0]), final-lane flag
//   in_bytes              valid bytes in final lane (0..8, >8 means 8)
//   blk_valid/blk_ready   rate block handshake
//   blk_data              block, lane k at [64k+63:64k]
//   blk_first/blk_last    first / final (padded) block of a message
module sha3_pad_packer #(
  parameter int         RATE_LANES = 17,
  parameter logic [7:0] DOMAIN     = 8'h06
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_data,
  input  logic                       in_last,
  input  logic [3:0]                 in_bytes,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic [64*RATE_LANES-1:0]   blk_data,
  output logic                       blk_first,
  output logic                       blk_last
);

  localparam int BW  = 64 * RATE_LANES;
  localparam int LCW = $clog2(RATE_LANES);
  localparam int PW  = $clog2(8 * RATE_LANES + 1);

  localparam logic [LCW-1:0] LAST_LANE  = LCW'(RATE_LANES - 1);
  localparam logic [PW-1:0]  RATE_BYTES = PW'(8 * RATE_LANES);

  typedef enum logic {
    S_FILL = 1'b0,
    S_OUT  = 1'b1
  } state_t;

  state_t           r_state;
  logic [LCW-1:0]   r_lane_cnt;
  logic [BW-1:0]    r_buf;
  logic             r_blk_first;
  logic             r_blk_last;
  logic             r_first_flag;
  logic             r_pend_pad;

  state_t           w_state_nx;
  logic [LCW-1:0]   w_cnt_nx;
  logic [BW-1:0]    w_buf_nx;
  logic             w_first_nx;
  logic             w_last_nx;
  logic             w_ff_nx;
  logic             w_pend_nx;

  logic             w_acc;
  logic [3:0]       w_nb;
  logic [63:0]      w_lane_m;
  logic [PW-1:0]    w_p;
  logic [BW-1:0]    w_pad_blk;

  assign in_ready  = (r_state == S_FILL) & rst_n;
  assign blk_valid = (r_state == S_OUT);
  assign blk_data  = r_buf;
  assign blk_first = r_blk_first;
  assign blk_last  = r_blk_last;

  assign w_acc = in_valid & in_ready;
  assign w_nb  = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
  assign w_p   = (PW'(r_lane_cnt) << 3) + PW'(w_nb);

  // Keep only the first w_nb bytes of the final lane.
  always_comb begin
    w_lane_m = '0;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < w_nb)
        w_lane_m[8*b +: 8] = in_data[8*b +: 8];
    end
  end

  // Padding block used when the message exactly filled the rate.
  always_comb begin
    w_pad_blk             = '0;
    w_pad_blk[7:0]        = DOMAIN;
    w_pad_blk[BW-1 -: 8]  = 8'h80;
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_lane_cnt;
    w_buf_nx   = r_buf;
    w_first_nx = r_blk_first;
    w_last_nx  = r_blk_last;
    w_ff_nx    = r_first_flag;
    w_pend_nx  = r_pend_pad;
    unique case (r_state)
      S_FILL: begin
        if (w_acc) begin
          if (in_last) begin
            w_buf_nx[64*r_lane_cnt +: 64] = w_lane_m;
            w_state_nx = S_OUT;
            w_first_nx = r_first_flag;
            w_ff_nx    = 1'b0;
            if (w_p < RATE_BYTES) begin
              // Domain and final 0x80 may land in the same byte.
              w_buf_nx[8*w_p +: 8] =
                w_buf_nx[8*w_p +: 8] | DOMAIN;
              w_buf_nx[BW-1 -: 8] =
                w_buf_nx[BW-1 -: 8] | 8'h80;
              w_last_nx = 1'b1;
            end else begin
              w_last_nx = 1'b0;
              w_pend_nx = 1'b1;
            end
          end else begin
            w_buf_nx[64*r_lane_cnt +: 64] = in_data;
            if (r_lane_cnt == LAST_LANE) begin
              w_state_nx = S_OUT;
              w_first_nx = r_first_flag;
              w_last_nx  = 1'b0;
              w_ff_nx    = 1'b0;
            end else begin
              w_cnt_nx = r_lane_cnt + LCW'(1);
            end
          end
        end
      end
      S_OUT: begin
        if (blk_ready) begin
          if (r_pend_pad) begin
            w_buf_nx   = w_pad_blk;
            w_first_nx = 1'b0;
            w_last_nx  = 1'b1;
            w_pend_nx  = 1'b0;
          end else begin
            w_buf_nx   = '0;
            w_cnt_nx   = '0;
            w_state_nx = S_FILL;
            if (r_blk_last)
              w_ff_nx = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_FILL;
      r_lane_cnt   <= '0;
      r_buf        <= '0;
      r_blk_first  <= 1'b0;
      r_blk_last   <= 1'b0;
      r_first_flag <= 1'b1;
      r_pend_pad   <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_lane_cnt   <= w_cnt_nx;
      r_buf        <= w_buf_nx;
      r_blk_first  <= w_first_nx;
      r_blk_last   <= w_last_nx;
      r_first_flag <= w_ff_nx;
      r_pend_pad   <= w_pend_nx;
    end
  end

endmodule

// File: tb/tb_sha3_pad_packer.sv
// tb_sha3_pad_packer: directed checks of lane packing, pad10*1,
// first/last flags, backpressure and mid-fill reset.
module tb_sha3_pad_packer;

  localparam int BW = 1088;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          blk_valid;
  logic          blk_ready;
  logic [BW-1:0] blk_data;
  logic          blk_first;
  logic          blk_last;

  int n_vec;
  int n_err;

  logic [BW-1:0] e_empty;
  logic [BW-1:0] e_abc;
  logic [BW-1:0] e;
  logic [BW-1:0] e2;

  sha3_pad_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag,
                         input logic [BW-1:0] obs,
                         input logic [BW-1:0] exp);
    int k;
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      k = 0;
      for (int i = 16; i >= 0; i--)
        if (obs[64*i +: 64] !== exp[64*i +: 64]) k = i;
      $error("FAIL %s lane%0d observed=%h expected=%h",
             tag, k, obs[64*k +: 64], exp[64*k +: 64]);
    end
  endtask

  task automatic beat(input logic [63:0] d,
                      input logic        l,
                      input logic [3:0]  nb);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_bytes = nb;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 4'd0;
    in_data  = '0;
  endtask

  task automatic take();
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
  endtask

  task automatic lanes(input int n);
    for (int k = 0; k < n; k++)
      beat({8{8'(k + 1)}}, 1'b0, 4'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_bytes  = 4'd0;
    blk_ready = 1'b0;

    e_empty            = '0;
    e_empty[7:0]       = 8'h06;
    e_empty[1087:1080] = 8'h80;
    e_abc              = '0;
    e_abc[63:0]        = 64'h0000_0000_0663_6261;
    e_abc[1087:1080]   = 8'h80;

    // Reset state
    step();
    step();
    chk("rst_valid", 64'(blk_valid), 64'd0);
    chk("rst_first", 64'(blk_first), 64'd0);
    chk("rst_last", 64'(blk_last), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk_blk("rst_data", blk_data, '0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 64'(in_ready), 64'd1);

    // 1: empty message, data must be ignored
    beat(64'hDEAD_BEEF_0BAD_F00D, 1'b1, 4'd0);
    chk("t1_valid", 64'(blk_valid), 64'd1);
    chk("t1_first", 64'(blk_first), 64'd1);
    chk("t1_last", 64'(blk_last), 64'd1);
    chk("t1_inrdy", 64'(in_ready), 64'd0);
    chk_blk("t1_data", blk_data, e_empty);
    take();
    chk("t1_done", 64'(blk_valid), 64'd0);
    chk("t1_inrdy2", 64'(in_ready), 64'd1);

    // 2: "abc" with junk in the unused upper bytes
    beat(64'hA5A5_A5A5_A563_6261, 1'b1, 4'd3);
    chk("t2_valid", 64'(blk_valid), 64'd1);
    chk("t2_first", 64'(blk_first), 64'd1);
    chk("t2_last", 64'(blk_last), 64'd1);
    chk_blk("t2_data", blk_data, e_abc);
    take();

    // 3: 135 bytes, domain and 0x80 merge into 0x86
    lanes(16);
    chk("t3_nvalid", 64'(blk_valid), 64'd0);
    chk("t3_inrdy", 64'(in_ready), 64'd1);
    beat(64'hFFEE_DDCC_BBAA_9988, 1'b1, 4'd7);
    e = '0;
    for (int k = 0; k < 16; k++)
      e[64*k +: 64] = {8{8'(k + 1)}};
    e[1087:1024] = 64'h86EE_DDCC_BBAA_9988;
    chk("t3_valid", 64'(blk_valid), 64'd1);
    chk("t3_first", 64'(blk_first), 64'd1);
    chk("t3_last", 64'(blk_last), 64'd1);
    chk_blk("t3_data", blk_data, e);
    take();

    // 4: 136 bytes (in_bytes 12 clamps to 8) -> extra pad block
    lanes(16);
    beat(64'h0123_4567_89AB_CDEF, 1'b1, 4'd12);
    e[1087:1024] = 64'h0123_4567_89AB_CDEF;
    chk("t4a_valid", 64'(blk_valid), 64'd1);
    chk("t4a_first", 64'(blk_first), 64'd1);
    chk("t4a_last", 64'(blk_last), 64'd0);
    chk_blk("t4a_data", blk_data, e);
    take();
    chk("t4b_valid", 64'(blk_valid), 64'd1);
    chk("t4b_first", 64'(blk_first), 64'd0);
    chk("t4b_last", 64'(blk_last), 64'd1);
    chk_blk("t4b_data", blk_data, e_empty);
    take();
    chk("t4_done", 64'(blk_valid), 64'd0);

    // 4c: 17 full lanes then "abc": two blocks, flags split
    lanes(17);
    e2 = e;
    e2[1087:1024] = {8{8'd17}};
    chk("t4c_valid", 64'(blk_valid), 64'd1);
    chk("t4c_first", 64'(blk_first), 64'd1);
    chk("t4c_last", 64'(blk_last), 64'd0);
    chk_blk("t4c_data", blk_data, e2);
    take();
    beat(64'h0000_0000_0063_6261, 1'b1, 4'd3);
    chk("t4d_first", 64'(blk_first), 64'd0);
    chk("t4d_last", 64'(blk_last), 64'd1);
    chk_blk("t4d_data", blk_data, e_abc);
    take();

    // 5: backpressure, offered words must not be consumed
    beat(64'h0000_0000_0063_6261, 1'b1, 4'd3);
    in_valid = 1'b1;
    in_data  = 64'h1234_5678_9ABC_DEF0;
    in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t5_valid", 64'(blk_valid), 64'd1);
      chk("t5_inrdy", 64'(in_ready), 64'd0);
      chk_blk("t5_data", blk_data, e_abc);
    end
    in_valid = 1'b0;
    in_data  = '0;
    take();
    beat(64'h0, 1'b1, 4'd0);
    chk("t5_first", 64'(blk_first), 64'd1);
    chk_blk("t5_after", blk_data, e_empty);
    take();

    // 6: reset after 5 lanes discards the partial block
    lanes(5);
    rst_n = 1'b0;
    step();
    chk("t6_rvalid", 64'(blk_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    beat(64'h0000_0000_0063_6261, 1'b1, 4'd3);
    chk("t6_valid", 64'(blk_valid), 64'd1);
    chk("t6_first", 64'(blk_first), 64'd1);
    chk("t6_last", 64'(blk_last), 64'd1);
    chk_blk("t6_data", blk_data, e_abc);
    take();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
